updown_counter_mod: RTL and testbench

Parametrised up/down counter, successor to the fixed-width 4-bit enable/direction counter. Adds programmable modulus, runtime step size, synchronous parallel load, a registered wrap pulse and sticky overflow/underflow flags. It serves as the general-purpose event and timebase counter for the design's datapath and control blocks.

---
 rtl/counter_pkg.sv | 12 +
 rtl/udc_next_calc.sv | 53 +++++
 rtl/updown_counter_mod.sv | 86 ++++++++
 tb/tb_updown_counter_mod.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Full binary range of a WIDTH-bit register.
  function automatic int default_mod(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-count for the up/down counter: modular wrap or saturate,
// plus crossing indications in each direction.
module udc_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = default_mod(WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             dir_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_up_o,
  output logic             wrap_dn_o
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_m;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] res;

  assign cnt_x  = {1'b0, count_i};
  // A step of MOD or more is equivalent to its remainder.
  assign step_m = {1'b0, step_i} % MOD_W;
  assign sum    = cnt_x + step_m;

  always_comb begin
    res       = cnt_x;
    wrap_up_o = 1'b0;
    wrap_dn_o = 1'b0;
    if (dir_i == DIR_UP) begin
      if (sum >= MOD_W) begin
        wrap_up_o = 1'b1;
        res       = sat_i ? (MOD_W - 1'b1) : (sum - MOD_W);
      end else begin
        res = sum;
      end
    end else begin
      if (cnt_x < step_m) begin
        wrap_dn_o = 1'b1;
        res       = sat_i ? '0 : (cnt_x + MOD_W - step_m);
      end else begin
        res = cnt_x - step_m;
      end
    end
  end

  assign next_o = res[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, wrap pulse and sticky ovf/udf flags.
// Define UDC_SATURATE_EN to clamp at the bounds instead of wrapping.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = default_mod(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             udf
);

`ifdef UDC_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] nxt;
  logic             wrap_up, wrap_dn;

  udc_next_calc #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .count_i   (count_q),
    .step_i    (step),
    .dir_i     (up_down),
    .sat_i     (SAT),
    .next_o    (nxt),
    .wrap_up_o (wrap_up),
    .wrap_dn_o (wrap_dn)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_flags;
    udf_d   = udf_q & ~clr_flags;
    if (load) begin
      count_d = ({1'b0, load_val} > MAX_W) ? MAX_W[WIDTH-1:0] : load_val;
    end else if (en) begin
      count_d = nxt;
      wrap_d  = wrap_up | wrap_dn;
      // Setting beats a simultaneous clear.
      if (wrap_up) ovf_d = 1'b1;
      if (wrap_dn) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod, WIDTH=4, MOD=10; expectations follow
// UDC_SATURATE_EN when it is defined.
module tb_updown_counter_mod;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up_down, load, clr_flags;
  logic [W-1:0] step, load_val;
  logic [W-1:0] count;
  logic         wrap, ovf, udf;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(W), .MOD(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_down   (up_down),
    .step      (step),
    .load      (load),
    .load_val  (load_val),
    .clr_flags (clr_flags),
    .count     (count),
    .wrap      (wrap),
    .ovf       (ovf),
    .udf       (udf)
  );

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; en = 0; up_down = 1; step = 0; load = 0; load_val = 0; clr_flags = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // obs/exp packing: {count[3:0], wrap, ovf, udf}
  task automatic test_reset();
    idle();
    en = 1; step = 3; rst = 1;
    tick();
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd0, 3'b000})
      $display("FAIL reset: got %b expected %b", {count, wrap, ovf, udf}, 7'b0000000);
    else passed++;
    rst = 0; en = 0;
  endtask

  task automatic test_count_up();
    logic [6:0] e;
    do_reset();
    en = 1; up_down = 1; step = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef UDC_SATURATE_EN
      e = {(i < 9) ? 4'(i + 1) : 4'd9, i >= 9, i >= 9, 1'b0};
`else
      e = {4'((i + 1) % 10), i == 9, i >= 9, 1'b0};
`endif
      total++;
      if ({count, wrap, ovf, udf} !== e)
        $display("FAIL count_up[%0d]: got %b expected %b", i, {count, wrap, ovf, udf}, e);
      else passed++;
    end
  endtask

  task automatic test_load_down();
    logic [6:0] exp_tab [5];
`ifdef UDC_SATURATE_EN
    exp_tab = '{{4'd3, 3'b000}, {4'd0, 3'b101}, {4'd0, 3'b101}, {4'd0, 3'b101}, {4'd0, 3'b101}};
`else
    exp_tab = '{{4'd3, 3'b000}, {4'd9, 3'b101}, {4'd5, 3'b001}, {4'd1, 3'b001}, {4'd7, 3'b101}};
`endif
    do_reset();
    load = 1; load_val = 3;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== exp_tab[0])
      $display("FAIL load3: got %b expected %b", {count, wrap, ovf, udf}, exp_tab[0]);
    else passed++;
    load = 0; en = 1; up_down = 0; step = 4;
    for (int i = 1; i < 5; i++) begin
      tick();
      total++;
      if ({count, wrap, ovf, udf} !== exp_tab[i])
        $display("FAIL down[%0d]: got %b expected %b", i, {count, wrap, ovf, udf}, exp_tab[i]);
      else passed++;
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    load = 1; load_val = 14;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd9, 3'b000})
      $display("FAIL load_clamp: got %b expected %b", {count, wrap, ovf, udf}, {4'd9, 3'b000});
    else passed++;
    // Load beats count, and would otherwise have wrapped from 9.
    en = 1; up_down = 1; step = 1; load_val = 5;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd5, 3'b000})
      $display("FAIL load_over_en: got %b expected %b", {count, wrap, ovf, udf}, {4'd5, 3'b000});
    else passed++;
  endtask

  task automatic test_clr_flags();
    logic [6:0] e;
    do_reset();
    load = 1; load_val = 9;
    tick();
    load = 0; en = 1; up_down = 1; step = 1; clr_flags = 1;
    tick();
`ifdef UDC_SATURATE_EN
    e = {4'd9, 3'b110};
`else
    e = {4'd0, 3'b110};
`endif
    total++;
    if ({count, wrap, ovf, udf} !== e)
      $display("FAIL clr_vs_set: got %b expected %b", {count, wrap, ovf, udf}, e);
    else passed++;
    en = 0;
    tick();
    e = {e[6:3], 3'b000};
    total++;
    if ({count, wrap, ovf, udf} !== e)
      $display("FAIL clr_alone: got %b expected %b", {count, wrap, ovf, udf}, e);
    else passed++;
    // udf clears too
    clr_flags = 0; load = 1; load_val = 0;
    tick();
    load = 0; en = 1; up_down = 0; step = 2;
    tick();
    en = 0; clr_flags = 1;
    tick();
    total++;
    if (udf !== 1'b0)
      $display("FAIL clr_udf: got %b expected %b", udf, 1'b0);
    else passed++;
  endtask

  task automatic test_step_edge();
    logic [6:0] e;
    do_reset();
    load = 1; load_val = 4;
    tick();
    load = 0; en = 1; step = 0;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd4, 3'b000})
      $display("FAIL step_zero: got %b expected %b", {count, wrap, ovf, udf}, {4'd4, 3'b000});
    else passed++;
    // step 13 acts as 3: 4 -> 7, then 7 -> 10 crosses
    step = 13;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd7, 3'b000})
      $display("FAIL step_mod: got %b expected %b", {count, wrap, ovf, udf}, {4'd7, 3'b000});
    else passed++;
    tick();
`ifdef UDC_SATURATE_EN
    e = {4'd9, 3'b110};
`else
    e = {4'd0, 3'b110};
`endif
    total++;
    if ({count, wrap, ovf, udf} !== e)
      $display("FAIL step_mod_wrap: got %b expected %b", {count, wrap, ovf, udf}, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_tab [3];
`ifdef UDC_SATURATE_EN
    exp_tab = '{{4'd9, 3'b000}, {4'd9, 3'b110}, {4'd9, 3'b110}};
`else
    exp_tab = '{{4'd9, 3'b000}, {4'd8, 3'b110}, {4'd7, 3'b110}};
`endif
    do_reset();
    en = 1; up_down = 1; step = 9;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({count, wrap, ovf, udf} !== exp_tab[i])
        $display("FAIL b2b[%0d]: got %b expected %b", i, {count, wrap, ovf, udf}, exp_tab[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1; load_val = 9;
    tick();
    load = 0; en = 1; up_down = 1; step = 7;  // 9+7=16 -> 6 (sat: 9), ovf set
    tick();
    rst = 1;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd0, 3'b000})
      $display("FAIL rst_mid: got %b expected %b", {count, wrap, ovf, udf}, {4'd0, 3'b000});
    else passed++;
    rst = 0; step = 1;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd1, 3'b000})
      $display("FAIL after_rst: got %b expected %b", {count, wrap, ovf, udf}, {4'd1, 3'b000});
    else passed++;
    rst = 1; load = 1; load_val = 7;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd0, 3'b000})
      $display("FAIL rst_load: got %b expected %b", {count, wrap, ovf, udf}, {4'd0, 3'b000});
    else passed++;
    rst = 0; load = 0;
  endtask

`ifdef UDC_SATURATE_EN
  task automatic test_saturate();
    logic [6:0] exp_tab [3];
    exp_tab = '{{4'd9, 3'b110}, {4'd9, 3'b110}, {4'd9, 3'b110}};
    do_reset();
    load = 1; load_val = 7;
    tick();
    load = 0; en = 1; up_down = 1; step = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({count, wrap, ovf, udf} !== exp_tab[i])
        $display("FAIL sat_up[%0d]: got %b expected %b", i, {count, wrap, ovf, udf}, exp_tab[i]);
      else passed++;
    end
    en = 0; load = 1; load_val = 2;
    tick();
    load = 0; en = 1; up_down = 0; step = 5;
    tick();
    total++;
    if ({count, wrap, ovf, udf} !== {4'd0, 3'b111})
      $display("FAIL sat_down: got %b expected %b", {count, wrap, ovf, udf}, {4'd0, 3'b111});
    else passed++;
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_count_up();
    test_load_down();
    test_load_clamp();
    test_clr_flags();
    test_step_edge();
    test_back_to_back();
    test_reset_mid();
`ifdef UDC_SATURATE_EN
    test_saturate();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
